// File: rtl/lfsr_period_meter_if.sv
// -----------------------------------------------------------------------------
// lfsr_period_meter_if
// Groups the observed LFSR state word, the restart request and the measurement
// results of lfsr_period_meter into one bundle.
//
// Signals:
//   state_i   [BITS-1:0]  LFSR state word being observed
//   restart_i             discard results and re-arm the meter
//   period_o  [BITS:0]    last measured period (1..2^BITS)
//   valid_o               period_o holds a completed measurement
//   stuck_o               state word has not changed for STUCK_TICKS cycles
//   busy_o                a measurement is in progress
//
// Modports:
//   master  drives state_i/restart_i, observes the results (LFSR side / bench)
//   slave   the meter itself
// -----------------------------------------------------------------------------
interface lfsr_period_meter_if #(
    parameter int BITS = 5
);
    logic [BITS-1:0] state_i;
    logic            restart_i;
    logic [BITS:0]   period_o;
    logic            valid_o;
    logic            stuck_o;
    logic            busy_o;

    modport master (
        output state_i,
        output restart_i,
        input  period_o,
        input  valid_o,
        input  stuck_o,
        input  busy_o
    );

    modport slave (
        input  state_i,
        input  restart_i,
        output period_o,
        output valid_o,
        output stuck_o,
        output busy_o
    );
endinterface

// File: rtl/lfsr_period_meter.sv
// -----------------------------------------------------------------------------
// lfsr_period_meter
// Observes an LFSR state word every clock, detects each state advance and
// measures the cycle length: the number of advances until a captured reference
// state recurs. Measurement repeats continuously. A state word that stops
// changing for STUCK_TICKS cycles is flagged as stuck (lock-up, or a period-1
// loop, which cannot be told apart from lock-up).
//
// Ports:
//   clk        clock
//   reset_i    synchronous, active-high reset
//   bus        lfsr_period_meter_if.slave
//                state_i, restart_i in; period_o, valid_o, stuck_o, busy_o out
//
// Parameters:
//   BITS         width of the observed state word
//   STUCK_TICKS  cycles without a state change before stuck is declared (>= 2)
//
// Build option:
//   LFSR_PERIOD_MAX_HOLD_EN  when defined, period_o only takes a new period
//                            that is larger than the one it holds (maximum
//                            since reset/restart). Undefined: every completed
//                            period is published.
// -----------------------------------------------------------------------------
module lfsr_period_meter #(
    parameter int BITS        = 5,
    parameter int STUCK_TICKS = 12500
) (
    input  logic                 clk,
    input  logic                 reset_i,
    lfsr_period_meter_if.slave   bus
);

    localparam int IDLE_W = (STUCK_TICKS > 2) ? $clog2(STUCK_TICKS) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(STUCK_TICKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    // 2^BITS: a count that reaches this never returned to the reference state
    localparam logic [BITS:0]     CNT_OVF   = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0]     CNT_ONE   = {{BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_COUNT = 2'd1,
        ST_STUCK = 2'd2
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [BITS-1:0]   prev_q;
    logic              prev_ok_q;
    logic [BITS-1:0]   ref_q, ref_d;
    logic [BITS:0]     count_q, count_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [BITS:0]     period_q, period_d;
    logic              valid_q, valid_d;
    logic              stuck_q, stuck_d;

    logic              step_s;
    logic              hit_ref_s;
    logic [BITS:0]     count_inc_s;
    logic              publish_s;

    // prev_ok keeps the first sample after reset/restart from looking like an advance
    assign step_s      = prev_ok_q && (bus.state_i != prev_q);
    assign hit_ref_s   = (bus.state_i == ref_q);
    assign count_inc_s = count_q + CNT_ONE;

`ifdef LFSR_PERIOD_MAX_HOLD_EN
    assign publish_s = (count_inc_s > period_q);
`else
    assign publish_s = 1'b1;
`endif

    // Previous state word, sampled unconditionally for advance detection
    always_ff @(posedge clk) begin
        prev_q <= bus.state_i;
    end

    // Validity of prev_q: cleared by reset/restart, set one cycle later
    always_ff @(posedge clk) begin
        if (reset_i || bus.restart_i) begin
            prev_ok_q <= 1'b0;
        end else begin
            prev_ok_q <= 1'b1;
        end
    end

    // FSM state and measurement registers, reset takes priority over restart
    always_ff @(posedge clk) begin
        if (reset_i || bus.restart_i) begin
            fsm_q    <= ST_ARM;
            ref_q    <= '0;
            count_q  <= '0;
            idle_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            ref_q    <= ref_d;
            count_q  <= count_d;
            idle_q   <= idle_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    // Next-state and datapath update for the ARM / COUNT / STUCK sequence
    always_comb begin
        fsm_d    = fsm_q;
        ref_d    = ref_q;
        count_d  = count_q;
        idle_d   = idle_q;
        period_d = period_q;
        valid_d  = valid_q;
        stuck_d  = stuck_q;

        case (fsm_q)
            ST_ARM: begin
                // Whatever is on state_i now becomes the reference, so an
                // advance landing in this cycle is absorbed, not counted.
                ref_d   = bus.state_i;
                count_d = '0;
                idle_d  = '0;
                fsm_d   = ST_COUNT;
            end

            ST_COUNT: begin
                if (step_s) begin
                    if (hit_ref_s) begin
                        if (publish_s) begin
                            period_d = count_inc_s;
                        end else begin
                            period_d = period_q;
                        end
                        valid_d = 1'b1;
                        fsm_d   = ST_ARM;
                    end else begin
                        count_d = count_inc_s;
                        idle_d  = '0;
                        // More steps than there are states: we are on a tail
                        // that never revisits ref, so re-arm without publishing.
                        if (count_inc_s == CNT_OVF) begin
                            fsm_d = ST_ARM;
                        end else begin
                            fsm_d = ST_COUNT;
                        end
                    end
                end else begin
                    if (idle_q == IDLE_LAST) begin
                        idle_d  = idle_q;
                        stuck_d = 1'b1;
                        fsm_d   = ST_STUCK;
                    end else begin
                        idle_d = idle_q + IDLE_ONE;
                        fsm_d  = ST_COUNT;
                    end
                end
            end

            ST_STUCK: begin
                if (step_s) begin
                    stuck_d = 1'b0;
                    fsm_d   = ST_ARM;
                end else begin
                    fsm_d = ST_STUCK;
                end
            end

            default: begin
                fsm_d = ST_ARM;
            end
        endcase
    end

    assign bus.period_o = period_q;
    assign bus.valid_o  = valid_q;
    assign bus.stuck_o  = stuck_q;
    assign bus.busy_o   = (fsm_q != ST_STUCK);

endmodule
